// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU step controller:
//   - state_e       : controller FSM encoding (also driven out on state_o)
//   - DEF_*         : default synchroniser depth and button debounce length
//   - deb_cnt_w()   : width of a debounce counter able to hold 0..n
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_HALTED    = 2'b11
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  // ceil(log2(n+1)), never narrower than one bit.
  function automatic int unsigned deb_cnt_w(input int unsigned n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// Brings an asynchronous level into the clk domain, qualifies it with a
// stability counter and emits a single-cycle pulse on its debounced rising
// edge.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset; clears every flop
//   din_i   in  raw asynchronous input
//   rise_o  out one-cycle pulse (combinational) on the debounced 0->1 edge
//
// With DEBOUNCE_CYCLES = 1 the debounced level is the synchronised input
// itself and the level register acts as the plain previous-value flop, so the
// pulse appears in the same cycle the last synchroniser stage goes high.
// -----------------------------------------------------------------------------
module sync_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o
);

  localparam int unsigned   CW      = deb_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // The counter saturates at CNT_MAX so a long hold cannot wrap it back
  // through zero and fake a second press.
  always_comb begin
    cnt_d = '0;
    if (synced) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    lvl_d = (cnt_d == CNT_MAX);
  end

  assign rise_o = lvl_d & ~lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

endmodule

// File: rtl/cpu_step_controller.sv
// -----------------------------------------------------------------------------
// cpu_step_controller
// Turns the divided clock from the clock divider into a single-cycle clock
// enable for the multicycle CPU, with run / single-step / halt control and a
// count of issued enables.
//
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   tick_in     in  divided clock (rco), asynchronous to clk
//   mode_run    in  1 = free-run mode
//   step_btn    in  raw single-step button (asynchronous, bouncy)
//   halt_req    in  forces HALTED; dominates everything else
//   cpu_en      out one-clk enable pulse to the CPU
//   tick_count  out number of cpu_en pulses since reset (wraps)
//   state_o     out current FSM state (cpu_ctrl_pkg::state_e encoding)
// -----------------------------------------------------------------------------
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [CNT_W-1:0] tick_count,
  output logic [1:0]       state_o
);

  logic             tick_rise;
  logic             step_press;
  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q;

  // The tick path needs no filtering, only edge detection.
  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(1)
  ) u_tick_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i (tick_in),
    .rise_o(tick_rise)
  );

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i (step_btn),
    .rise_o(step_press)
  );

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    if (halt_req) begin
      // A tick landing in the same cycle as the halt is deliberately lost.
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // mode_run wins over a simultaneous press; the step is dropped.
          if (mode_run) begin
            state_d = ST_RUN;
          end else if (step_press) begin
            state_d = ST_STEP_WAIT;
          end
        end
        ST_RUN: begin
          // Leaving RUN does not swallow a tick that arrives in that cycle.
          en_d = tick_rise;
          if (!mode_run) begin
            state_d = ST_IDLE;
          end
        end
        ST_STEP_WAIT: begin
          // Extra presses are not looked at here, so they never queue.
          if (tick_rise) begin
            en_d    = 1'b1;
            state_d = mode_run ? ST_RUN : ST_IDLE;
          end else if (mode_run) begin
            state_d = ST_RUN;
          end
        end
        ST_HALTED: begin
          // Software acknowledges the halt by dropping mode_run.
          if (!mode_run) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      // Counts together with the enable it accounts for; wraps silently.
      if (en_d) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cpu_en     = en_q;
  assign tick_count = cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_controller
// Directed bench for cpu_step_controller (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// CNT_W=4 so the counter wrap is reachable). Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cpu_step_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick_in;
  logic          mode_run;
  logic          step_btn;
  logic          halt_req;
  logic          cpu_en;
  logic [CW-1:0] tick_count;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_step_controller #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
    .mode_run  (mode_run),
    .step_btn  (step_btn),
    .halt_req  (halt_req),
    .cpu_en    (cpu_en),
    .tick_count(tick_count),
    .state_o   (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // n square-wave periods of 8 clk in RUN. A rise driven at phase 0 is
  // sampled by the next posedge and must show on cpu_en two edges later,
  // i.e. at the phase-2 sample; the count steps with that pulse.
  task automatic run_ticks(input int n, input int base);
    for (int e = 0; e < n; e++) begin
      for (int p = 0; p < 8; p++) begin
        tick_in = (p < 4);
        @(negedge clk);
        check("run_en", 32'(cpu_en), 32'(p == 2));
        if (p == 2) check("run_cnt", 32'(tick_count), (base + e + 1) % 16);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    tick_in  = 1'b0;
    mode_run = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;

    // Reset held while tick_in toggles.
    for (int i = 0; i < 8; i++) begin
      tick_in = ((i % 4) < 2);
      @(negedge clk);
      check("rst_en", 32'(cpu_en), 32'd0);
      check("rst_cnt", 32'(tick_count), 32'd0);
      check("rst_state", 32'(state_o), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick_in = (i < 12) && ((i % 4) < 2);
      @(negedge clk);
      check("idle_en", 32'(cpu_en), 32'd0);
      check("idle_state", 32'(state_o), 32'd0);
    end

    // Free-run: 10 rises -> 10 pulses.
    mode_run = 1'b1;
    @(negedge clk);
    check("run_entry", 32'(state_o), 32'd1);
    run_ticks(10, 0);
    check("run_total", 32'(tick_count), 32'd10);
    check("run_state", 32'(state_o), 32'd1);

    // Single step with a bouncing then held button and tick_in running.
    // Clean high driven at c=4 -> press -> STEP_WAIT visible at c=9; the
    // tick rise driven at c=8 becomes the pulse seen at c=10.
    mode_run = 1'b0;
    @(negedge clk);
    check("step_idle", 32'(state_o), 32'd0);
    for (int c = 0; c < 40; c++) begin
      step_btn = (c == 0) || (c == 2) || (c >= 4);
      tick_in  = ((c % 8) < 4);
      @(negedge clk);
      check("step_en", 32'(cpu_en), 32'(c == 10));
      check("step_state", 32'(state_o), (c == 9) ? 32'd2 : 32'd0);
    end
    check("step_cnt", 32'(tick_count), 32'd11);
    step_btn = 1'b0;
    tick_in  = 1'b0;
    repeat (4) @(negedge clk);

    // Halt collides with a tick rise.
    mode_run = 1'b1;
    @(negedge clk);
    check("halt_run", 32'(state_o), 32'd1);
    for (int p = 0; p < 8; p++) begin
      tick_in  = (p < 4);
      halt_req = (p >= 2);
      @(negedge clk);
      check("halt_en", 32'(cpu_en), 32'd0);
      check("halt_state", 32'(state_o), (p >= 2) ? 32'd3 : 32'd1);
    end
    halt_req = 1'b0;
    for (int p = 0; p < 8; p++) begin
      tick_in = (p < 4);
      @(negedge clk);
      check("halt_hold_en", 32'(cpu_en), 32'd0);
      check("halt_hold_state", 32'(state_o), 32'd3);
    end
    mode_run = 1'b0;
    @(negedge clk);
    check("halt_exit", 32'(state_o), 32'd0);
    check("halt_cnt", 32'(tick_count), 32'd11);

    // Reset while a step is pending.
    tick_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step_btn = 1'b1;
      @(negedge clk);
    end
    check("pend_state", 32'(state_o), 32'd2);
    step_btn = 1'b0;
    repeat (4) @(negedge clk);
    check("pend_hold", 32'(state_o), 32'd2);
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_cnt", 32'(tick_count), 32'd0);
    check("arst_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 8; p++) begin
      tick_in = (p < 4);
      @(negedge clk);
      check("post_rst_en", 32'(cpu_en), 32'd0);
      check("post_rst_state", 32'(state_o), 32'd0);
    end
    check("post_rst_cnt", 32'(tick_count), 32'd0);

    // Counter wrap: 17 rises -> 1..15, 0, 1.
    mode_run = 1'b1;
    @(negedge clk);
    run_ticks(17, 0);
    check("wrap_final", 32'(tick_count), 32'd1);
    check("wrap_state", 32'(state_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
